md5_auth_ctrl: RTL and testbench

Password-authentication sequencer that sits in front of the `md5` hashing core. It accepts a password one byte per cycle and builds the single padded 512-bit MD5 block. It drives the core's newtext/load handshake with four 128-bit chunks, then compares the returned digest against a stored reference hash. It reports pass/fail, counts consecutive failures and enforces a lockout until an explicit unlock.

---
 rtl/md5_auth_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_md5_auth_ctrl.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md5_auth_ctrl.sv
// md5_auth_ctrl
// Password-authentication sequencer placed in front of an MD5 hashing core.
// Collects a password one byte per cycle, builds the single padded 512-bit
// MD5 block, feeds it to the core as four 128-bit chunks through the
// newtext/load handshake, then compares the returned digest with a stored
// reference hash. Consecutive failures are counted and lead to a lockout
// that only an explicit unlock pulse clears.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   char_valid/data/last  password byte stream (last marks the final byte)
//   char_ready            a byte is accepted when char_valid & char_ready
//   ref_hash              expected digest in core output format
//   unlock                pulse: clears failure count and lockout
//   md5_newtext/load/data handshake and data towards the core
//   md5_ready/digest      completion and digest from the core
//   done                  one-cycle pulse at the end of an attempt
//   match, error          attempt result, held until the next attempt starts
//   locked                lockout active
//   fail_count            consecutive failures, saturating
module md5_auth_ctrl #(
    parameter int MAX_LEN    = 55,
    parameter int LOCK_LIMIT = 3,
    parameter int TIMEOUT    = 127
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         char_valid,
    input  logic [7:0]   char_data,
    input  logic         char_last,
    output logic         char_ready,
    input  logic [127:0] ref_hash,
    input  logic         unlock,
    output logic         md5_newtext,
    output logic         md5_load,
    output logic [127:0] md5_data,
    input  logic         md5_ready,
    input  logic [127:0] md5_digest,
    output logic         done,
    output logic         match,
    output logic         error,
    output logic         locked,
    output logic [1:0]   fail_count
);

    localparam int              TW        = $clog2(TIMEOUT + 1);
    localparam logic [5:0]      MAX_LEN_L = 6'(MAX_LEN);
    localparam logic [5:0]      LEN_SAT   = 6'(MAX_LEN + 1);
    localparam logic [1:0]      LOCK_L    = 2'(LOCK_LIMIT);
    localparam logic [TW-1:0]   TIMEOUT_L = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_INIT,
        ST_LOAD,
        ST_WAIT,
        ST_REPORT,
        ST_LOCKED
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [511:0]    buffer;
    logic [5:0]      len;
    logic            overflow;
    logic [1:0]      load_idx;
    logic [TW-1:0]   timer;

    logic            accept;
    logic            overflow_now;
    logic            attempt_pass;
    logic [1:0]      fail_next;
    logic [8:0]      byte_lsb;

    assign accept       = char_valid & char_ready;
    // The byte being accepted overflows if the buffer is already full.
    assign overflow_now = overflow | (len >= MAX_LEN_L);
    assign attempt_pass = match & ~error;
    assign fail_next    = (fail_count < LOCK_L) ? fail_count + 2'd1 : fail_count;

    // Message byte i lives in word i/4 (word 0 at the top of the buffer),
    // little-endian inside the word, so byte 4k occupies the word's low byte.
    assign byte_lsb = 9'd480 - 9'({len[5:2], 5'b00000}) + 9'({len[1:0], 3'b000});

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and the purely state-driven outputs.
    always_comb begin
        next_state  = state;
        char_ready  = 1'b0;
        md5_newtext = 1'b0;
        md5_load    = 1'b0;
        md5_data    = '0;
        done        = 1'b0;
        locked      = 1'b0;
        case (state)
            ST_IDLE: begin
                char_ready = 1'b1;
                if (char_valid) begin
                    next_state = char_last ? ST_INIT : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                char_ready = 1'b1;
                if (accept && char_last) begin
                    next_state = overflow_now ? ST_REPORT : ST_INIT;
                end
            end
            ST_INIT: begin
                md5_newtext = 1'b1;
                next_state  = ST_LOAD;
            end
            ST_LOAD: begin
                md5_load = 1'b1;
                case (load_idx)
                    2'd0:    md5_data = buffer[511:384];
                    2'd1:    md5_data = buffer[383:256];
                    2'd2:    md5_data = buffer[255:128];
                    default: md5_data = buffer[127:0];
                endcase
                if (load_idx == 2'd3) begin
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (md5_ready || (timer == TIMEOUT_L)) begin
                    next_state = ST_REPORT;
                end
            end
            ST_REPORT: begin
                done = 1'b1;
                // An unlock in this cycle beats both the increment and the lockout.
                if (!unlock && !attempt_pass && (fail_next == LOCK_L)) begin
                    next_state = ST_LOCKED;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                locked = 1'b1;
                if (unlock) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Datapath: block assembly, padding, counters and the result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            buffer     <= '0;
            len        <= '0;
            overflow   <= 1'b0;
            load_idx   <= '0;
            timer      <= '0;
            match      <= 1'b0;
            error      <= 1'b0;
            fail_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        buffer          <= '0;
                        buffer[487:480] <= char_data;
                        len             <= 6'd1;
                        overflow        <= 1'b0;
                        match           <= 1'b0;
                        error           <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (accept) begin
                        if (len < MAX_LEN_L) begin
                            buffer[byte_lsb +: 8] <= char_data;
                        end else begin
                            overflow <= 1'b1;
                        end
                        if (len != LEN_SAT) begin
                            len <= len + 6'd1;
                        end
                        if (char_last && overflow_now) begin
                            error <= 1'b1;
                            match <= 1'b0;
                        end
                    end
                end
                ST_INIT: begin
                    buffer[byte_lsb +: 8] <= 8'h80;
                    buffer[63:32]         <= {23'd0, len, 3'b000};
                    buffer[31:0]          <= '0;
                    load_idx              <= '0;
                end
                ST_LOAD: begin
                    load_idx <= load_idx + 2'd1;
                    timer    <= '0;
                end
                ST_WAIT: begin
                    if (md5_ready) begin
                        match <= (md5_digest == ref_hash);
                    end else if (timer == TIMEOUT_L) begin
                        error <= 1'b1;
                        match <= 1'b0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ST_REPORT: begin
                    fail_count <= attempt_pass ? 2'd0 : fail_next;
                end
                default: ;
            endcase
            if (unlock) begin
                fail_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_md5_auth_ctrl.sv
// Testbench for md5_auth_ctrl. A stand-in MD5 core captures the four loaded
// chunks and answers with a digest after a programmable latency; the real
// MD5 of "abc" is returned for the "abc" block and a toy hash otherwise.
// Expected chunks and attempt results come from a byte-level model of MD5
// padding and of the pass/fail/lockout rules, pushed into queues that a
// monitor drains whenever the DUT loads a chunk or signals done.
module tb_md5_auth_ctrl;

    localparam logic [511:0] ABC_BLOCK = {128'h80636261_00000000_00000000_00000000,
                                          256'h0,
                                          128'h00000000_00000000_00000018_00000000};
    localparam logic [127:0] ABC_DIGEST = 128'h98500190_b04fd23c_7d3f96d6_727fe128;

    typedef struct {
        logic       m;
        logic       e;
        logic [1:0] fc;
        logic       lk;
    } result_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         char_valid = 1'b0;
    logic [7:0]   char_data = 8'h00;
    logic         char_last = 1'b0;
    logic         char_ready;
    logic [127:0] ref_hash = ABC_DIGEST;
    logic         unlock = 1'b0;
    logic         md5_newtext;
    logic         md5_load;
    logic [127:0] md5_data;
    logic         md5_ready = 1'b0;
    logic [127:0] md5_digest = '0;
    logic         done;
    logic         match;
    logic         error;
    logic         locked;
    logic [1:0]   fail_count;

    int           vectors = 0;
    int           miscompares = 0;
    byte unsigned secret[$];
    int           fc_model = 0;
    result_t      result_q[$];
    logic [127:0] chunk_q[$];
    bit           fc_pending = 1'b0;
    result_t      fc_exp;
    int           newtext_seen = 0;

    int           core_latency = 10;
    bit           core_silent = 1'b0;
    int           load_cnt = 0;
    bit           core_pending = 1'b0;
    int           core_delay = 0;
    logic [511:0] core_blk = '0;

    always #5 clk = ~clk;

    md5_auth_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_last  (char_last),
        .char_ready (char_ready),
        .ref_hash   (ref_hash),
        .unlock     (unlock),
        .md5_newtext(md5_newtext),
        .md5_load   (md5_load),
        .md5_data   (md5_data),
        .md5_ready  (md5_ready),
        .md5_digest (md5_digest),
        .done       (done),
        .match      (match),
        .error      (error),
        .locked     (locked),
        .fail_count (fail_count)
    );

    // Standard MD5 single-block padding built as a 64-byte message.
    function automatic logic [511:0] model_block(input byte unsigned pw[$]);
        byte unsigned msg[64];
        logic [31:0]  bitlen;
        logic [511:0] blk;
        for (int i = 0; i < 64; i++) msg[i] = 8'h00;
        for (int i = 0; i < pw.size(); i++) msg[i] = pw[i];
        msg[pw.size()] = 8'h80;
        bitlen  = 32'(pw.size() * 8);
        msg[56] = bitlen[7:0];
        msg[57] = bitlen[15:8];
        msg[58] = bitlen[23:16];
        msg[59] = bitlen[31:24];
        blk = '0;
        for (int k = 0; k < 16; k++) begin
            blk = {blk[479:0], msg[4*k+3], msg[4*k+2], msg[4*k+1], msg[4*k]};
        end
        return blk;
    endfunction

    function automatic logic [127:0] fake_digest(input logic [511:0] blk);
        logic [127:0] h;
        if (blk == ABC_BLOCK) return ABC_DIGEST;
        h = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
        for (int j = 0; j < 4; j++) begin
            h = {h[120:0], h[127:121]} ^ blk[511-128*j -: 128];
        end
        return h ^ 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3;
    endfunction

    function automatic bit same_pw(input byte unsigned a[$], input byte unsigned b[$]);
        if (a.size() != b.size()) return 1'b0;
        for (int i = 0; i < a.size(); i++) if (a[i] != b[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Stand-in MD5 core.
    always @(negedge clk) begin
        md5_ready = 1'b0;
        if (reset) begin
            load_cnt     = 0;
            core_pending = 1'b0;
        end else begin
            if (md5_newtext === 1'b1) begin
                load_cnt     = 0;
                core_pending = 1'b0;
            end
            if (md5_load === 1'b1 && load_cnt < 4) begin
                core_blk[511-128*load_cnt -: 128] = md5_data;
                load_cnt++;
                if (load_cnt == 4) begin
                    core_pending = !core_silent;
                    core_delay   = core_latency;
                end
            end else if (core_pending) begin
                core_delay--;
                if (core_delay <= 0) begin
                    md5_ready    = 1'b1;
                    md5_digest   = fake_digest(core_blk);
                    core_pending = 1'b0;
                end
            end
        end
    end

    // Monitor: drains the scoreboard queues as the DUT produces output.
    always @(negedge clk) begin
        result_t r;
        if (fc_pending) begin
            checkOutput("fail_count", 128'(fail_count), 128'(fc_exp.fc));
            checkOutput("locked", 128'(locked), 128'(fc_exp.lk));
            fc_pending = 1'b0;
        end
        if (md5_newtext === 1'b1) newtext_seen++;
        if (md5_load === 1'b1) begin
            if (chunk_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL load_chunk: got %0h, required no load at %0t", md5_data, $time);
            end else begin
                checkOutput("load_chunk", md5_data, chunk_q.pop_front());
            end
        end
        if (done === 1'b1) begin
            if (result_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL done: got unexpected done, required none at %0t", $time);
            end else begin
                r = result_q.pop_front();
                checkOutput("match", 128'(match), 128'(r.m));
                checkOutput("error", 128'(error), 128'(r.e));
                fc_exp     = r;
                fc_pending = 1'b1;
            end
        end
    end

    task automatic sendBytes(input byte unsigned pw[$]);
        int w;
        for (int i = 0; i < pw.size(); i++) begin
            if ($urandom_range(3) == 0) begin
                char_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            char_valid = 1'b1;
            char_data  = pw[i];
            char_last  = (i == pw.size() - 1);
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (char_ready !== 1'b1 && w < 50);
            if (char_ready !== 1'b1) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL char_ready: got %b, required 1 within 50 cycles", char_ready);
            end
            @(posedge clk);
            #1;
        end
        char_valid = 1'b0;
        char_last  = 1'b0;
    endtask

    task automatic applyStimulus(input byte unsigned pw[$], input bit silent, input int lat);
        logic [511:0] blk;
        bit           ovf;
        bit           pass;
        result_t      r;
        int           c;
        ovf          = pw.size() > 55;
        core_silent  = silent;
        core_latency = lat;
        newtext_seen = 0;
        if (!ovf) begin
            blk = model_block(pw);
            for (int j = 0; j < 4; j++) chunk_q.push_back(blk[511-128*j -: 128]);
        end
        pass = !ovf && !silent && same_pw(pw, secret);
        if (pass) fc_model = 0;
        else if (fc_model < 3) fc_model++;
        r.m  = pass;
        r.e  = ovf || silent;
        r.fc = 2'(fc_model);
        r.lk = (fc_model == 3);
        result_q.push_back(r);
        sendBytes(pw);
        c = 0;
        while (result_q.size() != 0 && c < 400) begin
            @(negedge clk);
            c++;
        end
        if (result_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL done_timeout: got no done, required done within 400 cycles");
            result_q.delete();
            chunk_q.delete();
        end
        repeat (2) @(negedge clk);
        checkOutput("newtext_pulses", 128'(newtext_seen), ovf ? 128'd0 : 128'd1);
        checkOutput("leftover_chunks", 128'(chunk_q.size()), 128'd0);
        chunk_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseUnlock();
        @(posedge clk);
        #1 unlock = 1'b1;
        @(posedge clk);
        #1 unlock = 1'b0;
        fc_model = 0;
        @(negedge clk);
        checkOutput("unlock_locked", 128'(locked), 128'd0);
        checkOutput("unlock_fail_count", 128'(fail_count), 128'd0);
        checkOutput("unlock_char_ready", 128'(char_ready), 128'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_char_ready"}, 128'(char_ready), 128'd1);
        checkOutput({tag, "_newtext"}, 128'(md5_newtext), 128'd0);
        checkOutput({tag, "_load"}, 128'(md5_load), 128'd0);
        checkOutput({tag, "_data"}, md5_data, 128'd0);
        checkOutput({tag, "_done"}, 128'(done), 128'd0);
        checkOutput({tag, "_match"}, 128'(match), 128'd0);
        checkOutput({tag, "_error"}, 128'(error), 128'd0);
        checkOutput({tag, "_locked"}, 128'(locked), 128'd0);
        checkOutput({tag, "_fail_count"}, 128'(fail_count), 128'd0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        byte unsigned abc[$];
        byte unsigned abd[$];
        byte unsigned pw[$];
        byte unsigned longpw[$];
        int           kind;
        int           n;

        abc = {8'h61, 8'h62, 8'h63};
        abd = {8'h61, 8'h62, 8'h64};
        secret = abc;
        ref_hash = ABC_DIGEST;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkResetState("reset");
        @(posedge clk);
        #1;

        $display("[TB] correct password abc");
        applyStimulus(abc, 1'b0, 64);
        $display("[TB] wrong password abd");
        applyStimulus(abd, 1'b0, 20);

        $display("[TB] drive into lockout");
        applyStimulus(abd, 1'b0, 5);
        pw = {8'h78};
        applyStimulus(pw, 1'b0, 1);
        char_valid = 1'b1;
        char_data  = 8'h61;
        char_last  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("char_ready_locked", 128'(char_ready), 128'd0);
        end
        checkOutput("locked_hold", 128'(locked), 128'd1);
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        char_last  = 1'b0;
        pulseUnlock();
        applyStimulus(abc, 1'b0, 30);

        $display("[TB] overflow with 56 bytes");
        longpw.delete();
        for (int i = 0; i < 56; i++) longpw.push_back(8'h41);
        applyStimulus(longpw, 1'b0, 10);

        $display("[TB] core timeout");
        applyStimulus(abc, 1'b1, 0);
        applyStimulus(abc, 1'b0, 3);

        $display("[TB] reset during second load");
        begin
            logic [511:0] blk;
            blk = model_block(abc);
            chunk_q.push_back(blk[511:384]);
            chunk_q.push_back(blk[383:256]);
            core_silent = 1'b0;
            sendBytes(abc);
            @(posedge clk);
            @(posedge clk);
            #1 reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
            fc_model = 0;
            @(negedge clk);
            checkResetState("midreset");
            checkOutput("midreset_chunks", 128'(chunk_q.size()), 128'd0);
            chunk_q.delete();
            @(posedge clk);
            #1;
        end
        applyStimulus(abc, 1'b0, 12);

        $display("[TB] randomized attempts");
        secret.delete();
        n = $urandom_range(20, 4);
        for (int i = 0; i < n; i++) secret.push_back(8'($urandom));
        ref_hash = fake_digest(model_block(secret));
        for (int t = 0; t < 24; t++) begin
            kind = $urandom_range(7);
            pw.delete();
            if (kind <= 2) begin
                pw = secret;
            end else if (kind <= 5) begin
                n = $urandom_range(55, 1);
                for (int i = 0; i < n; i++) pw.push_back(8'($urandom));
            end else if (kind == 6) begin
                n = $urandom_range(60, 56);
                for (int i = 0; i < n; i++) pw.push_back(8'($urandom));
            end else begin
                pw = secret;
            end
            applyStimulus(pw, kind == 7, $urandom_range(70, 1));
            if (fc_model == 3) pulseUnlock();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
